request_queue_mc: RTL and testbench

Multi-car successor to the single-car request register block. It holds shared hall-call queues (up/down) and one car-call queue per car.
- Rising edges of button inputs are captured, so requests latch rather than XOR-toggle every cycle.
- Calls are cleared per car at that car's one-hot floor position.
- Each hall call carries an age counter that raises an "urgent" flag for the dispatcher.
- Sits between button/panel inputs and the dispatch/controller FSMs.

---
 rtl/request_queue_mc_pkg.sv | 23 ++
 rtl/request_queue_mc_if.sv | 35 +++
 rtl/request_queue_mc_age_cell.sv | 44 ++++
 rtl/request_queue_mc.sv | 108 ++++++++++
 tb/tb_request_queue_mc.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/request_queue_mc_pkg.sv
// Shared constants and helpers for the multi-car request queue.
package lift_req_pkg;

    localparam int CAR_MODE_SET    = 0;
    localparam int CAR_MODE_TOGGLE = 1;

    // Upper bound on floor-vector width accepted by popcount().
    localparam int POP_MAX_W = 64;

    function automatic int cnt_width(input int n_floors);
        return $clog2(n_floors + 1);
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/request_queue_mc_if.sv
// Button/panel inputs and queue outputs of the request queue.
interface request_queue_mc_if #(
    parameter int N_FLOORS = 12,
    parameter int N_CARS   = 2,
    parameter int CNT_W    = 4
);
    logic [N_FLOORS-1:0]        i_up_rqst;
    logic [N_FLOORS-1:0]        i_dn_rqst;
    logic [N_CARS*N_FLOORS-1:0] i_car_rqst;
    logic [N_CARS*N_FLOORS-1:0] i_car_pos;
    logic [N_CARS-1:0]          i_up_clr;
    logic [N_CARS-1:0]          i_dn_clr;
    logic [N_CARS-1:0]          i_car_clr;
    logic [N_FLOORS-1:0]        o_up_queue;
    logic [N_FLOORS-1:0]        o_dn_queue;
    logic [N_CARS*N_FLOORS-1:0] o_car_queue;
    logic [N_FLOORS-1:0]        o_up_urgent;
    logic [N_FLOORS-1:0]        o_dn_urgent;
    logic [N_CARS*CNT_W-1:0]    o_car_cnt;
    logic                       o_any_pending;

    modport master (
        output i_up_rqst, i_dn_rqst, i_car_rqst, i_car_pos,
        output i_up_clr, i_dn_clr, i_car_clr,
        input  o_up_queue, o_dn_queue, o_car_queue,
        input  o_up_urgent, o_dn_urgent, o_car_cnt, o_any_pending
    );

    modport slave (
        input  i_up_rqst, i_dn_rqst, i_car_rqst, i_car_pos,
        input  i_up_clr, i_dn_clr, i_car_clr,
        output o_up_queue, o_dn_queue, o_car_queue,
        output o_up_urgent, o_dn_urgent, o_car_cnt, o_any_pending
    );
endinterface

// File: rtl/request_queue_mc_age_cell.sv
// One hall-call bit with its saturating age counter and urgent flag.
module req_age_cell #(
    parameter int AGE_W     = 8,
    parameter int AGE_LIMIT = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic set_i,
    input  logic clr_i,
    output logic pend_o,
    output logic urgent_o
);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] LIMIT   = AGE_W'(AGE_LIMIT);

    logic             pend_q, pend_d;
    logic [AGE_W-1:0] age_q, age_d;

    // Clear wins over a coincident press: the car is serving this floor.
    always_comb begin
        pend_d = pend_q;
        if (clr_i)      pend_d = 1'b0;
        else if (set_i) pend_d = 1'b1;
    end

    always_comb begin
        age_d = age_q;
        if (!pend_q || set_i || clr_i) age_d = '0;
        else if (age_q != AGE_MAX)     age_d = age_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
            age_q  <= '0;
        end else begin
            pend_q <= pend_d;
            age_q  <= age_d;
        end
    end

    assign pend_o   = pend_q;
    assign urgent_o = pend_q && (age_q >= LIMIT);
endmodule

// File: rtl/request_queue_mc.sv
// Multi-car request queue: shared up/down hall calls with ageing, per-car car calls.
module request_queue_mc
    import lift_req_pkg::*;
#(
    parameter int N_FLOORS      = 12,
    parameter int N_CARS        = 2,
    parameter int TOGGLE_CANCEL = 1,
    parameter int AGE_W         = 8,
    parameter int AGE_LIMIT     = 200
) (
    input logic clk,
    input logic reset,
    request_queue_mc_if.slave bus
);
    localparam int CNT_W = cnt_width(N_FLOORS);
    localparam int NB    = N_CARS * N_FLOORS;

    logic [N_FLOORS-1:0] up_prev_q, dn_prev_q;
    logic [NB-1:0]       car_prev_q;
    logic [N_FLOORS-1:0] up_prs, dn_prs;
    logic [NB-1:0]       car_prs;
    logic [N_FLOORS-1:0] up_clr_mask, dn_clr_mask;
    logic [N_FLOORS-1:0] up_q, dn_q, up_urg, dn_urg;
    logic [NB-1:0]       car_q, car_d;
    logic [N_CARS*CNT_W-1:0] cnt_all;

    // Prev samples reset to 0 so a button held through reset counts as a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_prev_q  <= '0;
            dn_prev_q  <= '0;
            car_prev_q <= '0;
        end else begin
            up_prev_q  <= bus.i_up_rqst;
            dn_prev_q  <= bus.i_dn_rqst;
            car_prev_q <= bus.i_car_rqst;
        end
    end

    assign up_prs  = bus.i_up_rqst  & ~up_prev_q;
    assign dn_prs  = bus.i_dn_rqst  & ~dn_prev_q;
    assign car_prs = bus.i_car_rqst & ~car_prev_q;

    always_comb begin
        up_clr_mask = '0;
        dn_clr_mask = '0;
        for (int c = 0; c < N_CARS; c++) begin
            up_clr_mask = up_clr_mask |
                ({N_FLOORS{bus.i_up_clr[c]}} & bus.i_car_pos[c*N_FLOORS +: N_FLOORS]);
            dn_clr_mask = dn_clr_mask |
                ({N_FLOORS{bus.i_dn_clr[c]}} & bus.i_car_pos[c*N_FLOORS +: N_FLOORS]);
        end
    end

    for (genvar f = 0; f < N_FLOORS; f++) begin : g_hall
        req_age_cell #(.AGE_W(AGE_W), .AGE_LIMIT(AGE_LIMIT)) u_up (
            .clk      (clk),
            .reset    (reset),
            .set_i    (up_prs[f]),
            .clr_i    (up_clr_mask[f]),
            .pend_o   (up_q[f]),
            .urgent_o (up_urg[f])
        );
        req_age_cell #(.AGE_W(AGE_W), .AGE_LIMIT(AGE_LIMIT)) u_dn (
            .clk      (clk),
            .reset    (reset),
            .set_i    (dn_prs[f]),
            .clr_i    (dn_clr_mask[f]),
            .pend_o   (dn_q[f]),
            .urgent_o (dn_urg[f])
        );
    end

    for (genvar c = 0; c < N_CARS; c++) begin : g_car
        logic [N_FLOORS-1:0] clr;
        assign clr = {N_FLOORS{bus.i_car_clr[c]}} & bus.i_car_pos[c*N_FLOORS +: N_FLOORS];
        if (TOGGLE_CANCEL == CAR_MODE_TOGGLE) begin : g_toggle
            assign car_d[c*N_FLOORS +: N_FLOORS] =
                (car_q[c*N_FLOORS +: N_FLOORS] ^ car_prs[c*N_FLOORS +: N_FLOORS]) & ~clr;
        end else begin : g_set
            assign car_d[c*N_FLOORS +: N_FLOORS] =
                (car_q[c*N_FLOORS +: N_FLOORS] | car_prs[c*N_FLOORS +: N_FLOORS]) & ~clr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) car_q <= '0;
        else       car_q <= car_d;
    end

    always_comb begin
        logic [POP_MAX_W-1:0] pop_in;
        cnt_all = '0;
        for (int c = 0; c < N_CARS; c++) begin
            pop_in = '0;
            pop_in[N_FLOORS-1:0] = car_q[c*N_FLOORS +: N_FLOORS];
            cnt_all[c*CNT_W +: CNT_W] = CNT_W'(popcount(pop_in));
        end
    end

    assign bus.o_up_queue    = up_q;
    assign bus.o_dn_queue    = dn_q;
    assign bus.o_car_queue   = car_q;
    assign bus.o_up_urgent   = up_urg;
    assign bus.o_dn_urgent   = dn_urg;
    assign bus.o_car_cnt     = cnt_all;
    assign bus.o_any_pending = (|up_q) | (|dn_q) | (|car_q);
endmodule

// File: tb/tb_request_queue_mc.sv
// Directed bench for request_queue_mc: 12 floors, 2 cars, toggle-cancel, AGE_W=4, AGE_LIMIT=10.
module tb_request_queue_mc;
    localparam int NF = 12;
    localparam int NC = 2;
    localparam int CW = 4;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_bad;

    request_queue_mc_if #(.N_FLOORS(NF), .N_CARS(NC), .CNT_W(CW)) bus ();

    request_queue_mc #(
        .N_FLOORS(NF), .N_CARS(NC), .TOGGLE_CANCEL(1), .AGE_W(4), .AGE_LIMIT(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " up"},   32'(bus.o_up_queue),    32'h0);
        chk({tag, " dn"},   32'(bus.o_dn_queue),    32'h0);
        chk({tag, " car"},  32'(bus.o_car_queue),   32'h0);
        chk({tag, " uurg"}, 32'(bus.o_up_urgent),   32'h0);
        chk({tag, " durg"}, 32'(bus.o_dn_urgent),   32'h0);
        chk({tag, " cnt"},  32'(bus.o_car_cnt),     32'h0);
        chk({tag, " any"},  32'(bus.o_any_pending), 32'h0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.i_up_rqst  = '0;
        bus.i_dn_rqst  = '0;
        bus.i_car_rqst = '0;
        bus.i_car_pos  = '0;
        bus.i_up_clr   = '0;
        bus.i_dn_clr   = '0;
        bus.i_car_clr  = '0;

        cyc(1);
        chk_all_zero("rst");
        reset = 1'b0;
        cyc(1);

        // hold up[3] 5 cycles: no comb path, one press, stays after release
        bus.i_up_rqst = 12'h008;
        #1 chk("up3 no comb", 32'(bus.o_up_queue), 32'h0);
        cyc(1);
        chk("up3 set", 32'(bus.o_up_queue), 32'h008);
        chk("up3 any", 32'(bus.o_any_pending), 32'h1);
        cyc(4);
        bus.i_up_rqst = '0;
        cyc(2);
        chk("up3 held", 32'(bus.o_up_queue), 32'h008);
        bus.i_car_pos = 24'h000_008;
        bus.i_up_clr  = 2'b01;
        cyc(1);
        chk("up3 clr", 32'(bus.o_up_queue), 32'h0);
        bus.i_up_clr  = '0;
        bus.i_car_pos = '0;

        // car toggle: car0 floor2, car1 floor7 (bit 19), held 3 cycles
        bus.i_car_rqst = 24'h080_004;
        cyc(3);
        chk("car held", 32'(bus.o_car_queue), 32'h080004);
        chk("car cnt 1/1", 32'(bus.o_car_cnt), 32'h11);
        bus.i_car_rqst = '0;
        cyc(1);
        bus.i_car_rqst = 24'h080_000;
        cyc(1);
        chk("car1 cancel", 32'(bus.o_car_queue), 32'h000004);
        chk("car cnt 0/1", 32'(bus.o_car_cnt), 32'h01);
        bus.i_car_rqst = '0;
        bus.i_car_pos  = 24'h004_004;
        bus.i_car_clr  = 2'b10;
        cyc(1);
        chk("car1 clr no effect on car0", 32'(bus.o_car_queue), 32'h000004);
        bus.i_car_clr = 2'b01;
        cyc(1);
        chk("car0 clr", 32'(bus.o_car_queue), 32'h0);
        bus.i_car_clr = '0;
        bus.i_car_pos = '0;

        // clear wins over a simultaneous new press
        bus.i_up_rqst = 12'h020;
        cyc(1);
        bus.i_up_rqst = '0;
        cyc(3);
        chk("up5 pend", 32'(bus.o_up_queue), 32'h020);
        bus.i_up_rqst = 12'h020;
        bus.i_car_pos = 24'h000_020;
        bus.i_up_clr  = 2'b01;
        cyc(1);
        chk("up5 clr wins", 32'(bus.o_up_queue), 32'h0);
        bus.i_up_clr  = '0;
        bus.i_car_pos = '0;
        cyc(1);
        chk("up5 held no reset", 32'(bus.o_up_queue), 32'h0);
        bus.i_up_rqst = '0;
        cyc(1);

        // ageing on dn[2]: urgent after edge k+10, saturates without wrap
        bus.i_dn_rqst = 12'h004;
        cyc(1);
        bus.i_dn_rqst = '0;
        chk("dn2 set", 32'(bus.o_dn_queue), 32'h004);
        chk("dn2 urg k", 32'(bus.o_dn_urgent), 32'h0);
        for (int i = 1; i <= 9; i++) begin
            cyc(1);
            chk($sformatf("dn2 urg k+%0d", i), 32'(bus.o_dn_urgent), 32'h0);
        end
        cyc(1);
        chk("dn2 urg k+10", 32'(bus.o_dn_urgent), 32'h004);
        for (int i = 11; i <= 30; i++) begin
            cyc(1);
            chk($sformatf("dn2 sat k+%0d", i), 32'(bus.o_dn_urgent), 32'h004);
        end
        chk("up urg quiet", 32'(bus.o_up_urgent), 32'h0);
        bus.i_car_pos = 24'h004_000;
        bus.i_dn_clr  = 2'b10;
        cyc(1);
        chk("dn2 clr q", 32'(bus.o_dn_queue), 32'h0);
        chk("dn2 clr urg", 32'(bus.o_dn_urgent), 32'h0);
        bus.i_dn_clr  = '0;
        bus.i_car_pos = '0;

        // position checks: zero pos clears nothing, multi-hot clears all marked
        bus.i_up_rqst  = 12'h002;
        bus.i_dn_rqst  = 12'h203;
        bus.i_car_rqst = 24'h000_010;
        cyc(1);
        bus.i_up_rqst  = '0;
        bus.i_dn_rqst  = '0;
        bus.i_car_rqst = '0;
        bus.i_up_clr   = 2'b11;
        bus.i_dn_clr   = 2'b11;
        bus.i_car_clr  = 2'b11;
        cyc(1);
        chk("pos0 up", 32'(bus.o_up_queue), 32'h002);
        chk("pos0 dn", 32'(bus.o_dn_queue), 32'h203);
        chk("pos0 car", 32'(bus.o_car_queue), 32'h000010);
        bus.i_up_clr  = '0;
        bus.i_car_clr = '0;
        bus.i_dn_clr  = 2'b01;
        bus.i_car_pos = 24'h000_003;
        cyc(1);
        chk("multihot dn", 32'(bus.o_dn_queue), 32'h200);
        chk("multihot up kept", 32'(bus.o_up_queue), 32'h002);
        bus.i_dn_clr  = '0;
        bus.i_car_pos = '0;

        // async reset mid-cycle flushes everything
        #2 reset = 1'b1;
        #1 chk_all_zero("mid rst");
        bus.i_car_rqst = 24'h000_001;
        cyc(1);
        reset = 1'b0;
        #1 chk("post rst pre-edge", 32'(bus.o_car_queue), 32'h0);
        cyc(1);
        chk("held thru rst", 32'(bus.o_car_queue), 32'h000001);

        // full car0 queue: count reaches N_FLOORS
        bus.i_car_rqst = 24'h000_fff;
        cyc(1);
        chk("car0 full", 32'(bus.o_car_queue), 32'h000fff);
        chk("car0 cnt 12", 32'(bus.o_car_cnt), 32'h0c);
        bus.i_car_rqst = '0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
